// File: rtl/cmsdk_ahb_to_flash16.sv
// AHB-Lite read-only bridge onto a 16-bit flash with a fixed number of wait states.
// Word reads are split into two halfword flash accesses; writes and misaligned words get ERROR.
module cmsdk_ahb_to_flash16 #(
    parameter int unsigned AW = 16,
    parameter int unsigned WS = 0
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [AW-1:0] HADDR,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    output logic [AW-2:0] flash_addr,
    input  logic [15:0]   flash_rdata
);

    localparam int unsigned CW = (WS < 1) ? 1 : $clog2(WS + 1);
    localparam logic [CW-1:0] WS_C = CW'(WS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACC_LO = 3'd1,
        S_ACC_HI = 3'd2,
        S_ERR1   = 3'd3,
        S_ERR2   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            hready_q, hready_d;
    logic            hresp_q, hresp_d;
    logic [31:0]     hrdata_q, hrdata_d;
    logic [AW-2:0]   faddr_q, faddr_d;
    logic            lane_q, lane_d;
    logic            word_q, word_d;

    logic            accept_c;
    logic            is_word_c;
    logic            err_c;
    logic            sample_c;
    logic            unused_c;

    // Address-phase decode, only meaningful while idle
    assign accept_c  = HSEL & HREADY & HTRANS[1];
    assign is_word_c = (HSIZE == 3'd2);
    assign err_c     = HWRITE | (is_word_c & (HADDR[1:0] != 2'b00));
    assign sample_c  = (cnt_q == WS_C);
    assign unused_c  = ^{HTRANS[0], HADDR[0]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
            hrdata_q <= '0;
            faddr_q  <= '0;
            lane_q   <= 1'b0;
            word_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            hrdata_q <= hrdata_d;
            faddr_q  <= faddr_d;
            lane_q   <= lane_d;
            word_q   <= word_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hready_d = hready_q;
        hresp_d  = hresp_q;
        hrdata_d = hrdata_q;
        faddr_d  = faddr_q;
        lane_d   = lane_q;
        word_d   = word_q;

        case (state_q)
            S_IDLE: begin
                hready_d = 1'b1;
                hresp_d  = 1'b0;
                if (accept_c) begin
                    if (err_c) begin
                        state_d  = S_ERR1;
                        hready_d = 1'b0;
                        hresp_d  = 1'b1;
                    end else begin
                        state_d  = S_ACC_LO;
                        hready_d = 1'b0;
                        cnt_d    = '0;
                        hrdata_d = '0;
                        faddr_d  = {HADDR[AW-1:2], (is_word_c ? 1'b0 : HADDR[1])};
                        lane_d   = ~is_word_c & HADDR[1];
                        word_d   = is_word_c;
                    end
                end
            end

            // Flash data is only trusted once WS cycles have elapsed on this address
            S_ACC_LO: begin
                if (sample_c) begin
                    if (word_q) begin
                        hrdata_d[15:0] = flash_rdata;
                        faddr_d[0]     = 1'b1;
                        cnt_d          = '0;
                        state_d        = S_ACC_HI;
                    end else begin
                        if (lane_q) begin
                            hrdata_d[31:16] = flash_rdata;
                        end else begin
                            hrdata_d[15:0] = flash_rdata;
                        end
                        hready_d = 1'b1;
                        state_d  = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_ACC_HI: begin
                if (sample_c) begin
                    hrdata_d[31:16] = flash_rdata;
                    hready_d        = 1'b1;
                    state_d         = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // Two-cycle ERROR response: low/ERROR, then high/ERROR
            S_ERR1: begin
                hready_d = 1'b1;
                hresp_d  = 1'b1;
                state_d  = S_ERR2;
            end

            S_ERR2: begin
                hready_d = 1'b1;
                hresp_d  = 1'b0;
                state_d  = S_IDLE;
            end

            default: begin
                hready_d = 1'b1;
                hresp_d  = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    assign HREADYOUT  = hready_q;
    assign HRESP      = hresp_q;
    assign HRDATA     = hrdata_q;
    assign flash_addr = faddr_q;

endmodule

// File: doc/cmsdk_ahb_to_flash16.md
Name: cmsdk_ahb_to_flash16

Overview:
- AHB-Lite read-only slave that bridges 32-bit AHB reads onto the 16-bit flash ROM model (flash_addr / flash_rdata interface).
- Sits directly upstream of the 16-bit flash behavioural model.
- Counts out the flash's fixed WS wait states per halfword access, and holds HREADYOUT low while it does so.
- Assembles one or two halfwords into HRDATA. Writes and unaligned word reads get an AHB ERROR response.

Parameters:
- AW, 16, byte address width of the flash region. The flash halfword address is AW-1 bits.
- WS, 0, flash wait states per halfword. Must equal the WS of the attached flash model.

Ports:
- HCLK  input  1  clock
- HRESETn  input  1  asynchronous active-low reset
- HSEL  input  1  slave select
- HADDR  input  AW  byte address
- HTRANS  input  2  transfer type. Bit 1 set means NONSEQ or SEQ.
- HSIZE  input  3  transfer size: 0 = byte, 1 = halfword, 2 = word
- HWRITE  input  1  write indicator
- HREADY  input  1  bus ready (address phase qualifier)
- HREADYOUT  output  1  slave ready
- HRESP  output  1  0 = OKAY, 1 = ERROR
- HRDATA  output  32  read data
- flash_addr  output  AW-1  halfword address to the flash
- flash_rdata  input  16  flash read data. Reads 0xFFFF while the flash is not ready.

Behaviour:
- Reset (asynchronous, HRESETn low), from any state: state=IDLE, cnt=0, HREADYOUT=1, HRESP=0, HRDATA=0, flash_addr=0.
  - A reset mid-access abandons the transfer and produces no response.
- Accept condition: HSEL & HREADY & HTRANS[1] in state IDLE. The cycle where this holds is called cycle A.
  - Address-phase signals are sampled only in cycle A.
  - HSEL low, or HTRANS IDLE/BUSY: no state change, response stays OKAY with HREADYOUT=1.
- Error path: accepted with HWRITE=1, or with HSIZE=2 and HADDR[1:0]!=0.
  - Next state is ERR1: HREADYOUT=0, HRESP=1.
  - Then ERR2: HREADYOUT=1, HRESP=1.
  - Then IDLE. The flash is not accessed and flash_addr is unchanged.
- Read accept, at the edge ending cycle A:
  - HRDATA <= 0, HREADYOUT <= 0, cnt <= 0, state <= ACC_LO.
  - flash_addr <= {HADDR[AW-1:2], (HSIZE==2) ? 1'b0 : HADDR[1]}.
  - Store a lane bit: 0 for word reads, HADDR[1] otherwise. Store is_word = (HSIZE==2).
- ACC_LO and ACC_HI: cnt increments each cycle.
  - When cnt==WS, sample flash_rdata on the next edge.
  - ACC_LO sample, word read: HRDATA[15:0] <= flash_rdata; flash_addr[0] <= 1; cnt <= 0; state <= ACC_HI.
  - ACC_LO sample, byte or halfword read: HRDATA[16*lane +: 16] <= flash_rdata; other lane stays 0; state <= IDLE; HREADYOUT <= 1.
    - Byte reads return the whole containing halfword. The master selects the byte lane.
  - ACC_HI sample: HRDATA[31:16] <= flash_rdata; state <= IDLE; HREADYOUT <= 1.
- Sampling point rationale: the flash output is valid no earlier than WS cycles after flash_addr changes.
  - The controller never samples before cnt==WS, even when the address is unchanged and the flash is ready earlier.
  - The controller therefore never captures the 0xFFFF not-ready value.
- Latency:
  - Byte or halfword read: HREADYOUT low for WS+1 cycles.
  - Word read: HREADYOUT low for 2*(WS+1) cycles.
  - HRDATA is registered and valid in the first HREADYOUT=1 cycle after the access.
- Pipelining:
  - The IDLE cycle that completes a transfer (HREADYOUT=1) is also the address phase of the next transfer. Back-to-back reads therefore work with no extra dead cycle.
  - HRDATA holds its value until the next read is accepted.
- cnt is sized ceil(log2(WS+1)), minimum 1 bit. It never exceeds WS.
- flash_addr holds its last value while in IDLE and in the error states.

Test Plan:
- Image byte[i] = i & 0xFF.
- WS=0, word read of HADDR=0x0004 -> flash_addr=0x0002 for 1 cycle, then 0x0003 for 1 cycle. HREADYOUT low 2 cycles, then HRDATA=0x07060504, HRESP=0.
- WS=2, halfword read of HADDR=0x0006 -> flash_addr=0x0003 for 3 cycles, HREADYOUT low 3 cycles, HRDATA=0x07060000. A checker confirms flash_rdata is never sampled while it reads 0xFFFF.
- WS=2, word read of HADDR=0x0010 -> HREADYOUT low 6 cycles, HRDATA=0x13121110. Then an immediate back-to-back byte read of HADDR=0x0021 -> HRDATA=0x00002120 after 3 low cycles.
- Write of HADDR=0x0000, then word read of HADDR=0x0002 -> each gives the two-cycle ERROR: (HREADYOUT=0, HRESP=1) then (HREADYOUT=1, HRESP=1). flash_addr is unchanged.
- WS=3, HRESETn asserted on the second ACC_HI cycle of a word read -> HREADYOUT=1, HRESP=0, HRDATA=0, flash_addr=0 immediately. A subsequent read of HADDR=0x0008 returns 0x0B0A0908.
- HSEL=0 or HTRANS=IDLE for 10 cycles -> HREADYOUT=1, HRESP=0, flash_addr and HRDATA unchanged.
